// File: rtl/fix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fix_pkg : Q7.8 format constants and multiplier tag type               |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fix_pkg;

  localparam int DATA    = 16;
  localparam int INTE    = 7;
  localparam int POIN    = 8;
  localparam int MUL_LAT = 3;
  // Tag id is sized for the largest supported requester count (8).
  localparam int ID_W    = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/fix_mul_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin one-hot grant with a next-start pointer      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found;
  int            idx;

  // Search starts at ptr and wraps; the first eligible requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (found) begin
      if (grant_idx == PW'(NREQ - 1)) ptr_next = '0;
      else                            ptr_next = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_next;
  end

endmodule
`default_nettype wire

// File: rtl/fix_mul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fix_mul_arbiter : shares one pipelined Q7.8 multiplier across NREQ    |
// | requesters with round-robin issue and per-requester result holding   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fix_mul_arbiter
  import fix_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA    = fix_pkg::DATA,
  parameter int MUL_LAT = fix_pkg::MUL_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DATA-1:0] req_a,
  input  logic [NREQ*DATA-1:0] req_b,
  output logic [NREQ-1:0]      res_valid,
  input  logic [NREQ-1:0]      res_ready,
  output logic [NREQ*DATA-1:0] res_data,
  output logic [DATA-1:0]      mul_a,
  output logic [DATA-1:0]      mul_b,
  input  logic [DATA-1:0]      mul_p,
  output logic [NREQ-1:0]      busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            accept;
  logic [NREQ-1:0] busy_q;
  logic [NREQ-1:0] res_valid_q;
  logic [NREQ-1:0] consume;
  logic [NREQ-1:0] capture;
  logic [DATA-1:0] held [NREQ];
  tag_t            issue_tag;
  tag_t            tag_pipe [MUL_LAT];
  tag_t            exit_tag;

  assign eligible = req_valid & ~busy_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .eligible  (eligible),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No grant is visible while reset is held.
  assign req_ready = grant & {NREQ{rst_n}};
  assign accept    = |grant;
  assign consume   = res_valid_q & res_ready;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;

  // issue_tag travels alongside mul_a/mul_b; tag_pipe mirrors the multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
    end else if (accept) begin
      mul_a     <= req_a[grant_idx*DATA +: DATA];
      mul_b     <= req_b[grant_idx*DATA +: DATA];
      issue_tag <= '{valid: 1'b1, id: ID_W'(grant_idx)};
    end else begin
      mul_a     <= '0;
      mul_b     <= '0;
      issue_tag <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int k = 1; k < MUL_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign exit_tag = tag_pipe[MUL_LAT-1];

  always_comb begin
    capture = '0;
    for (int i = 0; i < NREQ; i++) begin
      capture[i] = exit_tag.valid && (exit_tag.id == ID_W'(i));
    end
  end

  // Capture and consume never hit the same slot: one credit per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= '0;
      busy_q      <= '0;
      for (int i = 0; i < NREQ; i++) held[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capture[i]) begin
          held[i]        <= mul_p;
          res_valid_q[i] <= 1'b1;
        end else if (consume[i]) begin
          res_valid_q[i] <= 1'b0;
        end
        if (grant[i])        busy_q[i] <= 1'b1;
        else if (consume[i]) busy_q[i] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_res
    assign res_data[i*DATA +: DATA] = held[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_mul_arbiter.sv
`default_nettype none
// tb_fix_mul_arbiter : directed and random checks of the shared multiplier arbiter
// with a 3-stage rounding Q7.8 multiplier model on the mul_* port.
module tb_fix_mul_arbiter;

  localparam int N = 4;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*D-1:0] req_a;
  logic [N*D-1:0] req_b;
  logic [N-1:0]   res_valid;
  logic [N-1:0]   res_ready;
  logic [N*D-1:0] res_data;
  logic [D-1:0]   mul_a;
  logic [D-1:0]   mul_b;
  logic [D-1:0]   mul_p;
  logic [N-1:0]   busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [D-1:0] sbq [N][$];
  logic [D-1:0] m1, m2;
  logic [N-1:0] acc;
  int           flow_cnt;

  always #5 clk = ~clk;

  fix_mul_arbiter #(.NREQ(N), .DATA(D), .MUL_LAT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  function automatic logic [D-1:0] qmul(input logic [D-1:0] a, input logic [D-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    p = p + 32'sd128;
    return p[23:8];
  endfunction

  // External multiplier: three register stages from operand sample to mul_p.
  always @(posedge clk) begin
    m1    <= qmul(mul_a, mul_b);
    m2    <= m1;
    mul_p <= m2;
  end

  function automatic logic [D-1:0] rd(input int i);
    return res_data[i*D +: D];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [D-1:0] a, input logic [D-1:0] b);
    req_a[i*D +: D] = a;
    req_b[i*D +: D] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_exp [12];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = '0;
    req_a     = '0;
    req_b     = '0;
    #3;
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_res_data",  res_data[31:0], 0);
    check("rst_mul_a",     mul_a,     0);
    check("rst_mul_b",     mul_b,     0);
    do_reset();

    // Single op: 1.5 * 2.0 on requester 0
    set_op(0, 16'h0180, 16'h0200);
    req_valid = 4'b0001;
    #3;
    check("single_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("single_mul_a", mul_a, 16'h0180);
    check("single_mul_b", mul_b, 16'h0200);
    check("single_busy",  busy[0], 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("single_early", res_valid[0], 0);
    end
    tick();
    check("single_valid", res_valid[0], 1);
    check("single_data",  rd(0), 16'h0300);
    tick();
    check("single_consume_busy",  busy[0], 0);
    check("single_consume_valid", res_valid[0], 0);
    check("single_data_hold",     rd(0), 16'h0300);

    // Zero operand on requester 1, same latency
    set_op(1, 16'h0000, 16'h0300);
    req_valid = 4'b0010;
    #3;
    check("zero_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("zero_early", res_valid[1], 0);
    end
    tick();
    check("zero_valid", res_valid[1], 1);
    check("zero_data",  rd(1), 16'h0000);

    // Round-robin from reset, all requesters valid
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'((i + 1) * 256), 16'h0080);
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      #3;
      check($sformatf("rr_grant_%0d", c), req_ready, rr_exp[c]);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) tick();
    for (int i = 0; i < N; i++) check($sformatf("rr_data_%0d", i), rd(i), 32'((i + 1) * 128));

    // Back-pressure on requester 2
    do_reset();
    res_ready = 4'b1011;
    set_op(2, 16'h0300, 16'h0100);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    check("bp_valid_start", res_valid[2], 1);
    for (int i = 0; i < N; i++) if (i != 2) set_op(i, 16'h0100, 16'h0100);
    req_valid = '1;
    flow_cnt  = 0;
    for (int c = 0; c < 10; c++) begin
      #3;
      check("bp_no_grant2", req_ready[2], 0);
      if (req_ready != 0) flow_cnt++;
      tick();
      check("bp_hold_valid", res_valid[2], 1);
      check("bp_hold_data",  rd(2), 16'h0300);
    end
    check("bp_others_flow", 32'(flow_cnt >= 3), 1);
    res_ready = '1;
    tick();
    check("bp_release_busy",  busy[2], 0);
    check("bp_release_valid", res_valid[2], 0);

    // Reset mid-flight
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, 16'h0100, 16'h0200);
    req_valid = 4'b0111;
    tick();
    tick();
    tick();
    check("mid_busy", busy, 4'b0111);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      busy,      0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_mul_a",     mul_a,     0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_data",      res_data[31:0], 0);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("mid_no_late_valid", res_valid, 0);
    end
    req_valid = '1;
    #3;
    check("mid_next_grant", req_ready, 4'b0001);
    tick();

    // Random soak with per-requester in-order scoreboard
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      #3;
      check("soak_onehot", 32'($onehot0(req_ready)), 1);
      check("soak_credit", 32'(req_ready & busy), 0);
      acc = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) sbq[i].push_back(qmul(req_a[i*D +: D], req_b[i*D +: D]));
        if (res_valid[i] && res_ready[i]) begin
          check("soak_nodup", 32'(sbq[i].size() != 0), 1);
          if (sbq[i].size() != 0) check($sformatf("soak_data_%0d", i), rd(i), sbq[i].pop_front());
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          set_op(i, 16'($urandom), 16'($urandom));
        end
      end
      res_ready = 4'($urandom);
    end
    req_valid = '0;
    res_ready = '1;
    for (int c = 0; c < 20; c++) begin
      #3;
      for (int i = 0; i < N; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          check("drain_nodup", 32'(sbq[i].size() != 0), 1);
          if (sbq[i].size() != 0) check($sformatf("drain_data_%0d", i), rd(i), sbq[i].pop_front());
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) check($sformatf("soak_noloss_%0d", i), sbq[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
